// File: rtl/sprite_rom_arbiter.sv
// sprite_rom_arbiter
// Shares one registered sprite ROM read port between NUM_REQ pixel-fetch
// requesters. At most one read is accepted per cycle. The ROM address is
// registered, and the palette index returns to the winner two cycles after
// the accept edge, with a one-hot rvalid.
//
// Optional build macro: SPRITE_ARB_FIXED_PRIO_EN
//   defined   -> fixed priority; the lowest index wins and there is no rr pointer
//   undefined -> round-robin starting from rr (default)
module sprite_rom_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 19,
  parameter int DATA_W  = 4
) (
  input  logic                      Clk,
  input  logic                      Reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*ADDR_W-1:0] addr,
  input  logic                      enable,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [ADDR_W-1:0]         rom_addr,
  input  logic [DATA_W-1:0]         rom_data,
  output logic [NUM_REQ-1:0]        rvalid,
  output logic [DATA_W-1:0]         rdata,
  output logic                      busy
);

  localparam int RR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [ADDR_W-1:0]  addr_slice [NUM_REQ];
  logic [RR_W-1:0]    rr_reg;
  logic [NUM_REQ-1:0] gnt_next;
  logic [RR_W-1:0]    winner;
  logic               accept;
  int                 scan_idx;

  logic [ADDR_W-1:0]  rom_addr_reg;
  logic [NUM_REQ-1:0] tag1_reg;
  logic               v1_reg;
  logic [NUM_REQ-1:0] tag2_reg;
  logic               v2_reg;
  logic [NUM_REQ-1:0] rvalid_reg;
  logic [DATA_W-1:0]  rdata_reg;

  // Split the flat address bus into one slice per requester
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_addr_slice
    assign addr_slice[gi] = addr[gi*ADDR_W +: ADDR_W];
  end

  // Scan upward from rr (modulo NUM_REQ) and select the first active request
  always_comb begin
    gnt_next = '0;
    winner   = '0;
    scan_idx = 0;
    if (enable) begin
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
        scan_idx = int'(rr_reg) + k;
        if (scan_idx >= NUM_REQ) begin
          scan_idx = scan_idx - NUM_REQ;
        end
        // Scanning downward lets the lowest offset from rr overwrite the others
        if (req[scan_idx]) begin
          gnt_next           = '0;
          gnt_next[scan_idx] = 1'b1;
          winner             = RR_W'(scan_idx);
        end
      end
    end
  end

  // The grant is forced low while Reset is held, even though the flops are already cleared
  assign gnt    = Reset ? '0 : gnt_next;
  assign accept = |gnt_next;

`ifdef SPRITE_ARB_FIXED_PRIO_EN
  // Fixed priority: the scan always starts at index 0
  assign rr_reg = '0;
`else
  // Advance the round-robin pointer past the winner on every accept
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      rr_reg <= '0;
    end else if (accept) begin
      rr_reg <= (winner == RR_W'(NUM_REQ - 1)) ? '0 : winner + RR_W'(1);
    end
  end
`endif

  // Stage 1: register the winner's address for the ROM, along with its tag
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      rom_addr_reg <= '0;
      tag1_reg     <= '0;
      v1_reg       <= 1'b0;
    end else begin
      v1_reg <= accept;
      if (accept) begin
        rom_addr_reg <= addr_slice[winner];
        tag1_reg     <= gnt_next;
      end
    end
  end

  // Stage 2: follow the tag while the ROM performs its registered read
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      tag2_reg <= '0;
      v2_reg   <= 1'b0;
    end else begin
      tag2_reg <= tag1_reg;
      v2_reg   <= v1_reg;
    end
  end

  // Return stage: capture the ROM data and pulse the owner's valid for one cycle
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      rvalid_reg <= '0;
      rdata_reg  <= '0;
    end else begin
      rvalid_reg <= v2_reg ? tag2_reg : '0;
      if (v2_reg) begin
        rdata_reg <= rom_data;
      end
    end
  end

  assign rom_addr = rom_addr_reg;
  assign rvalid   = rvalid_reg;
  assign rdata    = rdata_reg;
  assign busy     = v1_reg | v2_reg | (|rvalid_reg);

endmodule

// File: doc/sprite_rom_arbiter.md
# sprite_rom_arbiter

Shares one registered sprite ROM read port (4-bit palette index, 1-cycle read latency) between up to NUM_REQ pixel-fetch requesters: doodler, stair, monster and tool drawers. Each cycle it accepts at most one read request using round-robin order, drives the ROM address, and returns the data to the granted requester two cycles later with a one-hot valid. It sits between the per-sprite drawing logic and a single on-chip sprite memory, so several sprites can share one block RAM.

## Interface
Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- ADDR_W, 19, ROM address width
- DATA_W, 4, ROM data width (palette index)

Ports:
- Clk  in  1  system clock; all state updates on the rising edge
- Reset  in  1  asynchronous, active-high reset
- req  in  NUM_REQ  per-requester read request; level, held until granted
- addr  in  NUM_REQ*ADDR_W  per-requester address; slice i is addr[i*ADDR_W +: ADDR_W]
- enable  in  1  arbitration enable; low means no new grants (for example during VGA blanking)
- gnt  out  NUM_REQ  one-hot grant, combinational, same cycle as the accepted req
- rom_addr  out  ADDR_W  registered address to the ROM read_address
- rom_data  in  DATA_W  ROM registered data_Out
- rvalid  out  NUM_REQ  one-hot read-return valid, one cycle wide
- rdata  out  DATA_W  returned data; qualified by rvalid
- busy  out  1  high while any read is in flight (stage 1 or stage 2 valid)

## Operation
- **Accept condition:** a transfer occurs on an edge where req[i] & gnt[i].
  - The requester may drop req or present a new address on the following cycle.
  - addr[i] must be stable while req[i] is high and ungranted.
- **Grant:**
  - gnt is zero when Reset, enable=0, or req=0.
  - Otherwise exactly one bit is set: the first requesting index found scanning upward from pointer rr, modulo NUM_REQ.
- **Round-robin pointer:**
  - rr has width clog2(NUM_REQ) and resets to 0.
  - On each accept, rr <= (winner+1) mod NUM_REQ.
  - With no accept, rr holds.
- **Pipeline stage 1, on the accept edge:**
  - rom_addr <= addr[winner]
  - tag1 <= one-hot winner
  - v1 <= 1
  - With no accept: v1 <= 0 and rom_addr holds its last value.
- **ROM:** samples rom_addr on the next edge; rom_data is valid after that edge.
- **Pipeline stage 2:**
  - tag2 <= tag1 and v2 <= v1.
  - One edge later: rvalid <= v2 ? tag2 : 0, and rdata <= rom_data if v2, else rdata holds.
- **Back-to-back:** one accept per cycle is sustained; returns come out in accept order, with no bubbles and no stalls.
- **busy** = v1 | v2 | (rvalid != 0).
- **enable deasserted mid-flight:** no new grants; in-flight reads still complete and return.
- **Starvation bound:** a requester holding req high is granted within NUM_REQ accept cycles while enable=1.

## Timing
- **Reset values** (asynchronous, immediate): gnt=0, rom_addr=0, rvalid=0, rdata=0, busy=0, rr=0, v1=v2=0, tag1=tag2=0.
- **Latency:** accept on edge E0 → rom_addr valid after E0 → ROM reads at E1 → rvalid/rdata valid after E2 for exactly one cycle (2 cycles after the accept edge).
- **Throughput:** 1 read per cycle.
- **Reset mid-operation:** all in-flight reads are discarded and no rvalid is produced for them; requesters must re-request.
- **Simultaneous events:**
  - When all requesters are active, grants rotate 0,1,2,3,0…
  - A requester that just received rvalid may be granted again in the same cycle.
- **Width rules:** the winner index is zero-extended into rr; the modulo wrap from NUM_REQ-1 goes to 0.

## Configuration
- SPRITE_ARB_FIXED_PRIO_EN
  - **Defined:** fixed priority, where the lowest-index requester always wins; rr is not implemented (treated as constant 0); the starvation bound does not apply.
  - **Undefined (default):** round-robin as specified above.
  - Pipeline, latency and reset behaviour are identical in both modes.

## Test plan
- **Single read:** req[2]=1, addr[2]=0x00123, ROM model mem[0x123]=0xA → gnt=4'b0100 same cycle; rom_addr=0x00123 after the edge; rvalid=4'b0100, rdata=0xA exactly 2 cycles after accept, for 1 cycle.
- **All four requesting continuously, enable=1 after reset:**
  - grants are 0,1,2,3,0,1 on consecutive cycles;
  - rvalid is the same sequence delayed 2 cycles;
  - each rdata matches its requester's address.
- **enable=0 with req=4'b1111:** gnt=0 and busy falls to 0 within 3 cycles. Re-enabling grants resume at rr (not reset to 0).
- **Reset mid-flight:** accept req[1], assert Reset 1 cycle later → rvalid stays 0 throughout, rr=0, rom_addr=0. After release, req[3] alone is granted the next cycle.
- **Starvation:** req[0] held constantly and req[3] raised → req[3] is granted within 4 cycles.
- **With SPRITE_ARB_FIXED_PRIO_EN:** req=4'b1010 held → gnt=4'b0010 every cycle and req[3] is never granted while req[1] is high.
